// File: rtl/multi_debounce_if.sv
// Signal bundle for the multi-channel debouncer.
// The master drives the switch/control side; the slave is the debouncer.
interface multi_debounce_if #(
    parameter int CH = 4
);
    logic [CH-1:0] sw_i;
    logic [1:0]    mode_i;
    logic [CH-1:0] irq_en_i;
    logic [CH-1:0] irq_clr_i;
    logic [CH-1:0] stable_o;
    logic [CH-1:0] pulse_o;
    logic [CH-1:0] long_o;
    logic [CH-1:0] irq_stat_o;
    logic          irq_o;

    modport master (
        output sw_i,
        output mode_i,
        output irq_en_i,
        output irq_clr_i,
        input  stable_o,
        input  pulse_o,
        input  long_o,
        input  irq_stat_o,
        input  irq_o
    );

    modport slave (
        input  sw_i,
        input  mode_i,
        input  irq_en_i,
        input  irq_clr_i,
        output stable_o,
        output pulse_o,
        output long_o,
        output irq_stat_o,
        output irq_o
    );
endinterface

// File: rtl/multi_debounce.sv
// Multi-channel switch debouncer with edge pulses, long-press
// detection and sticky per-channel interrupt status.
module multi_debounce #(
    parameter int CH          = 4,
    parameter int CNT_W       = 14,
    parameter int SYNC_STAGES = 2,
    parameter int LONG_TICKS  = 200,
    parameter bit ACTIVE_HIGH = 1'b0
) (
    input  logic            clk_i,
    input  logic            resetn_i,
    multi_debounce_if.slave bus
);

    localparam logic [7:0] LT = 8'(LONG_TICKS);

    logic [1:0]       rst_q;
    logic             rst_n;
    logic [CH-1:0]    sync_q [SYNC_STAGES];
    logic [CH-1:0]    sync;
    logic [CNT_W-1:0] pre_q;
    logic             tick;

    logic [CH-1:0] stable_q;
    logic [CH-1:0] pulse_q;
    logic [CH-1:0] long_q;
    logic [CH-1:0] stat_q;

    logic [CH-1:0] upd;
    logic [CH-1:0] pulse_d;
    logic [CH-1:0] long_d;
    logic [CH-1:0] stat_d;

    // Reset asserts at once but releases two edges later.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            rst_q <= '0;
        end else begin
            rst_q <= {rst_q[0], 1'b1};
        end
    end

    assign rst_n = rst_q[1];

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= bus.sw_i;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_q + CNT_W'(1);
        end
    end

    assign tick = &pre_q;

    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic [CNT_W-1:0] cnt_q;
        logic [7:0]       lcnt_q;
        logic             differ;
        logic             expire;
        logic             pressed;
        logic             lstep;
        logic             sel;

        assign differ  = sync[i] ^ stable_q[i];
        assign expire  = differ && (&cnt_q);
        assign pressed = (stable_q[i] == ACTIVE_HIGH);
        assign lstep   = pressed && tick && (lcnt_q != LT);

        always_ff @(posedge clk_i or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
            end else if (!differ || expire) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end

        // Saturates at LT so a held press reports only once.
        always_ff @(posedge clk_i or negedge rst_n) begin
            if (!rst_n) begin
                lcnt_q <= '0;
            end else if (!pressed) begin
                lcnt_q <= '0;
            end else if (lstep) begin
                lcnt_q <= lcnt_q + 8'd1;
            end
        end

        always_comb begin
            sel = 1'b0;
            unique case (bus.mode_i)
                2'b00:   sel = sync[i];
                2'b01:   sel = !sync[i];
                2'b10:   sel = 1'b1;
                default: sel = 1'b0;
            endcase
        end

        assign upd[i]     = expire;
        assign pulse_d[i] = expire && sel;
        assign long_d[i]  = lstep && (lcnt_q == LT - 8'd1);
    end

    // Set has priority over a same-cycle clear.
    assign stat_d = ((pulse_q | long_q) & bus.irq_en_i)
                  | (stat_q & ~bus.irq_clr_i);

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            stable_q <= '0;
            pulse_q  <= '0;
            long_q   <= '0;
            stat_q   <= '0;
        end else begin
            stable_q <= stable_q ^ upd;
            pulse_q  <= pulse_d;
            long_q   <= long_d;
            stat_q   <= stat_d;
        end
    end

    assign bus.stable_o   = stable_q;
    assign bus.pulse_o    = pulse_q;
    assign bus.long_o     = long_q;
    assign bus.irq_stat_o = stat_q;
    assign bus.irq_o      = |stat_q;

endmodule

// File: tb/tb_multi_debounce.sv
// Randomised and directed bench for multi_debounce against a
// window-based behavioural model of the debouncer.
module tb_multi_debounce;

    localparam int CH  = 4;
    localparam int CW  = 4;
    localparam int SS  = 2;
    localparam int LT  = 3;
    localparam bit AH  = 1'b1;
    localparam int WIN = 1 << CW;

    logic clk      = 1'b0;
    logic resetn_i = 1'b1;
    bit   cmp_on   = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    multi_debounce_if #(.CH(CH)) bus ();

    multi_debounce #(
        .CH(CH), .CNT_W(CW), .SYNC_STAGES(SS),
        .LONG_TICKS(LT), .ACTIVE_HIGH(AH)
    ) dut (
        .clk_i(clk),
        .resetn_i(resetn_i),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Model state: history of first-stage samples, newest first.
    bit            hist [CH][$];
    logic [CH-1:0] m_stable, m_pulse, m_long, m_stat;
    int            m_ticks [CH];
    int            rdly;
    int            act;

    function automatic bit mode_ok(logic [1:0] m, bit rising);
        case (m)
            2'b00:   return rising;
            2'b01:   return !rising;
            2'b10:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        rdly = 0;
        act = 0;
        m_stable = '0;
        m_pulse = '0;
        m_long = '0;
        m_stat = '0;
        for (int c = 0; c < CH; c++) begin
            hist[c].delete();
            repeat (SS + WIN) hist[c].push_back(1'b0);
            m_ticks[c] = 0;
        end
    endtask

    task automatic model_step();
        bit tick;
        bit all_diff;
        if (rdly < 2) begin
            rdly++;
            return;
        end
        m_stat = ((m_pulse | m_long) & bus.irq_en_i)
               | (m_stat & ~bus.irq_clr_i);
        tick = ((act % WIN) == WIN - 1);
        act++;
        for (int c = 0; c < CH; c++) begin
            m_long[c] = 1'b0;
            if (m_stable[c] != AH) begin
                m_ticks[c] = 0;
            end else if (tick && m_ticks[c] < LT) begin
                m_ticks[c]++;
                m_long[c] = (m_ticks[c] == LT);
            end
            // Flip once the synchronised input disagreed for a whole window.
            all_diff = 1'b1;
            for (int j = 0; j < WIN; j++) begin
                if (hist[c][SS-1+j] == m_stable[c]) all_diff = 1'b0;
            end
            m_pulse[c] = 1'b0;
            if (all_diff) begin
                m_stable[c] = !m_stable[c];
                m_pulse[c] = mode_ok(bus.mode_i, m_stable[c]);
            end
            hist[c].push_front(bus.sw_i[c]);
            void'(hist[c].pop_back());
        end
    endtask

    always @(posedge clk or negedge resetn_i) begin
        if (!resetn_i) model_reset();
        else model_step();
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            checks++;
            if (bus.stable_o !== m_stable || bus.pulse_o !== m_pulse ||
                bus.long_o !== m_long || bus.irq_stat_o !== m_stat ||
                bus.irq_o !== (|m_stat)) begin
                failures++;
                $display("FAIL model t=%0t stable=%b/%b pulse=%b/%b long=%b/%b stat=%b/%b irq=%b",
                         $time, bus.stable_o, m_stable, bus.pulse_o, m_pulse,
                         bus.long_o, m_long, bus.irq_stat_o, m_stat, bus.irq_o);
            end
        end
    end

    task automatic chk(string name, logic [31:0] actual, logic [31:0] req);
        checks++;
        if (actual !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, actual, req);
        end
    endtask

    // Edge index (1-based) at which stable_o[c] first reads v, or 0.
    task automatic wait_level(int c, bit v, int lim, output int e, output int pc);
        e = 0;
        pc = 0;
        for (int k = 1; k <= lim; k++) begin
            @(negedge clk);
            if (bus.pulse_o[c]) pc++;
            if (e == 0 && bus.stable_o[c] == v) e = k;
        end
    endtask

    task automatic count_pulses(int c, int n, inout int pc);
        repeat (n) begin
            @(negedge clk);
            if (bus.pulse_o[c]) pc++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int e, pc, chg, off, lc;
        bus.sw_i = '0;
        bus.mode_i = 2'b00;
        bus.irq_en_i = '0;
        bus.irq_clr_i = '0;
        #1 resetn_i = 1'b0;
        repeat (3) @(negedge clk);
        cmp_on = 1'b1;
        chk("reset_stable", 32'(bus.stable_o), 0);
        chk("reset_irq", 32'(bus.irq_o), 0);
        resetn_i = 1'b1;
        repeat (4) @(negedge clk);

        // Clean step on channel 0.
        bus.sw_i[0] = 1'b1;
        wait_level(0, 1'b1, 20, e, pc);
        chk("step_rise_edge", e, 18);
        chk("step_pulse_count", pc, 1);
        chk("step_other_ch", 32'(bus.stable_o[3:1]), 0);

        // Bouncing channel 1.
        chg = 0;
        pc = 0;
        for (int k = 0; k < 12; k++) begin
            bus.sw_i[1] = ~bus.sw_i[1];
            repeat (5) begin
                @(negedge clk);
                if (bus.stable_o[1]) chg++;
                if (bus.pulse_o[1]) pc++;
            end
        end
        chk("bounce_no_change", chg, 0);
        chk("bounce_no_pulse", pc, 0);
        bus.sw_i[1] = 1'b1;
        wait_level(1, 1'b1, 24, e, pc);
        chk("bounce_rise_edge", e, 18);
        chk("bounce_pulse", pc, 1);

        // Edge-select modes on channel 3.
        for (int m = 1; m < 4; m++) begin
            bus.mode_i = 2'(m);
            pc = 0;
            bus.sw_i[3] = 1'b1;
            count_pulses(3, 25, pc);
            bus.sw_i[3] = 1'b0;
            count_pulses(3, 25, pc);
            chk($sformatf("mode%0d_pulses", m), pc, (m == 1) ? 1 : (m == 2) ? 2 : 0);
        end
        bus.mode_i = 2'b00;

        // Long press on channel 2.
        bus.sw_i[2] = 1'b1;
        wait_level(2, 1'b1, 20, e, pc);
        chk("long_rise_edge", e, 18);
        off = 0;
        lc = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (bus.long_o[2]) begin
                lc++;
                if (off == 0) off = k;
            end
        end
        chk("long_offset_ok", 32'(off >= 33 && off <= 48), 1);
        chk("long_count", lc, 1);
        bus.sw_i[2] = 1'b0;
        repeat (25) @(negedge clk);

        // Interrupt status: set wins over a simultaneous clear.
        bus.irq_en_i = 4'b0001;
        bus.mode_i = 2'b10;
        bus.sw_i[0] = 1'b0;
        e = 0;
        for (int k = 0; k < 40 && e == 0; k++) begin
            @(negedge clk);
            if (bus.pulse_o[0]) e = 1;
        end
        chk("irq_pulse_seen", e, 1);
        bus.irq_clr_i[0] = 1'b1;
        @(negedge clk);
        bus.irq_clr_i[0] = 1'b0;
        chk("irq_set_wins", 32'(bus.irq_stat_o[0]), 1);
        repeat (2) @(negedge clk);
        bus.irq_clr_i[0] = 1'b1;
        @(negedge clk);
        bus.irq_clr_i[0] = 1'b0;
        chk("irq_cleared", 32'(bus.irq_o), 0);
        bus.sw_i[1] = 1'b0;
        repeat (25) @(negedge clk);
        chk("irq_disabled_ch", 32'(bus.irq_stat_o), 0);
        bus.sw_i[0] = 1'b1;
        repeat (25) @(negedge clk);
        chk("irq_set_again", 32'(bus.irq_o), 1);
        bus.irq_en_i = '0;
        repeat (3) @(negedge clk);
        chk("irq_en_off_keeps", 32'(bus.irq_stat_o[0]), 1);
        bus.mode_i = 2'b00;

        // Reset in the middle of a debounce window.
        bus.sw_i[3] = 1'b1;
        repeat (12) @(negedge clk);
        chk("pre_reset_stable0", 32'(bus.stable_o[0]), 1);
        @(posedge clk);
        #3 resetn_i = 1'b0;
        #1;
        chk("rst_stable", 32'(bus.stable_o), 0);
        chk("rst_pulse", 32'(bus.pulse_o), 0);
        chk("rst_long", 32'(bus.long_o), 0);
        chk("rst_stat", 32'(bus.irq_stat_o), 0);
        chk("rst_irq", 32'(bus.irq_o), 0);
        @(negedge clk);
        resetn_i = 1'b1;
        wait_level(3, 1'b1, 25, e, pc);
        chk("rst_release_rise", e, 20);
        chk("rst_release_pulse", pc, 1);

        // Randomised traffic.
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(39) == 0) bus.sw_i[c] = ~bus.sw_i[c];
            end
            if ($urandom_range(199) == 0) bus.mode_i = 2'($urandom_range(3));
            if ($urandom_range(99) == 0) bus.irq_en_i = 4'($urandom_range(15));
            bus.irq_clr_i = ($urandom_range(9) == 0) ? 4'($urandom_range(15)) : '0;
            if ($urandom_range(1499) == 0) begin
                @(posedge clk);
                #3 resetn_i = 1'b0;
                @(negedge clk);
                resetn_i = 1'b1;
            end
        end
        @(negedge clk);
        cmp_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
